// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Digit-serial adder/subtractor, LSB first, registered carry,
//               start/done handshake with ALU-style flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int C_N     = WIDTH / DIGIT;
    localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_add_sub: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [WIDTH-1:0]     r_a_q, w_a_d;
    logic [WIDTH-1:0]     r_b_q, w_b_d;
    logic [WIDTH-1:0]     r_p_q, w_p_d;
    logic                 r_carry_q, w_carry_d;
    logic [C_CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [WIDTH-1:0]     r_result_q, w_result_d;
    logic                 r_cout_q, w_cout_d;
    logic                 r_ovf_q, w_ovf_d;
    logic                 r_zero_q, w_zero_d;
    logic                 r_neg_q, w_neg_d;
    logic                 r_done_q, w_done_d;

    logic [DIGIT:0]       w_sum;
    logic [WIDTH-1:0]     w_p_shift;
    logic                 w_msb_cin;

    assign w_sum = {1'b0, r_a_q[DIGIT-1:0]} + {1'b0, r_b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry_q};
    // New sum digit enters from the MSB side so the LSB digit lands at bit 0 after N steps.
    assign w_p_shift = (r_p_q >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the top bit of this digit, recovered from its sum bit.
    assign w_msb_cin = r_a_q[DIGIT-1] ^ r_b_q[DIGIT-1] ^ w_sum[DIGIT-1];

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_p_d      = r_p_q;
        w_carry_d  = r_carry_q;
        w_cnt_d    = r_cnt_q;
        w_result_d = r_result_q;
        w_cout_d   = r_cout_q;
        w_ovf_d    = r_ovf_q;
        w_zero_d   = r_zero_q;
        w_neg_d    = r_neg_q;
        w_done_d   = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_a_d     = in1;
                    w_b_d     = sub ? ~in2 : in2;
                    w_carry_d = sub;
                    w_cnt_d   = '0;
                    w_p_d     = '0;
                    w_state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_a_d     = r_a_q >> DIGIT;
                w_b_d     = r_b_q >> DIGIT;
                w_p_d     = w_p_shift;
                w_carry_d = w_sum[DIGIT];
                w_cnt_d   = r_cnt_q + C_CNT_W'(1);
                if (r_cnt_q == C_LAST) begin
                    w_result_d = w_p_shift;
                    w_cout_d   = w_sum[DIGIT];
                    w_ovf_d    = w_msb_cin ^ w_sum[DIGIT];
                    w_zero_d   = (w_p_shift == '0);
                    w_neg_d    = w_p_shift[WIDTH-1];
                    w_done_d   = 1'b1;
                    w_cnt_d    = '0;
                    w_state_d  = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_p_q      <= '0;
            r_carry_q  <= 1'b0;
            r_cnt_q    <= '0;
            r_result_q <= '0;
            r_cout_q   <= 1'b0;
            r_ovf_q    <= 1'b0;
            r_zero_q   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_p_q      <= w_p_d;
            r_carry_q  <= w_carry_d;
            r_cnt_q    <= w_cnt_d;
            r_result_q <= w_result_d;
            r_cout_q   <= w_cout_d;
            r_ovf_q    <= w_ovf_d;
            r_zero_q   <= w_zero_d;
            r_neg_q    <= w_neg_d;
            r_done_q   <= w_done_d;
        end
    end

    assign busy     = (r_state_q == S_RUN);
    assign done     = r_done_q;
    assign result   = r_result_q;
    assign cout     = r_cout_q;
    assign overflow = r_ovf_q;
    assign zero     = r_zero_q;
    assign negative = r_neg_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Directed and randomised self-checking bench for serial_add_sub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

    localparam int C_DIGS [4] = '{1, 4, 8, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8 [2];
    logic        done8 [2];
    logic        cout8 [2];
    logic        ovf8  [2];
    logic        zero8 [2];
    logic        neg8  [2];
    logic [7:0]  res8  [2];

    logic        start64, sub64;
    logic [63:0] a64, b64;
    logic        busy64 [4];
    logic        done64 [4];
    logic        cout64 [4];
    logic        ovf64  [4];
    logic        zero64 [4];
    logic        neg64  [4];
    logic [63:0] res64  [4];

    int checks = 0;
    int errors = 0;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut8
            serial_add_sub #(.WIDTH(8), .DIGIT((g == 0) ? 1 : 4)) u_dut (
                .clk(clk), .reset(reset), .start(start8), .sub(sub8),
                .in1(a8), .in2(b8), .busy(busy8[g]), .done(done8[g]),
                .result(res8[g]), .cout(cout8[g]), .overflow(ovf8[g]),
                .zero(zero8[g]), .negative(neg8[g])
            );
        end
        for (genvar g = 0; g < 4; g++) begin : g_dut64
            serial_add_sub #(.WIDTH(64), .DIGIT(C_DIGS[g])) u_dut (
                .clk(clk), .reset(reset), .start(start64), .sub(sub64),
                .in1(a64), .in2(b64), .busy(busy64[g]), .done(done64[g]),
                .result(res64[g]), .cout(cout64[g]), .overflow(ovf64[g]),
                .zero(zero64[g]), .negative(neg64[g])
            );
        end
    endgenerate

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle8;
        for (int i = 0; i < 40 && (busy8[0] || busy8[1]); i++) tick();
    endtask

    // Launch one 8-bit operation and return cycles from the accepting edge to done.
    task automatic run8(input int idx, input logic s, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        wait_idle8();
        sub8 = s; a8 = x; b8 = y; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (done8[idx] === 1'b1) begin
                lat = t;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy8[0], done8[0], cout8[0], ovf8[0], zero8[0], neg8[0]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl8: got %b required 000000",
                     {busy8[0], done8[0], cout8[0], ovf8[0], zero8[0], neg8[0]});
        end
        checks++;
        if (res8[0] !== 8'h00 || res8[1] !== 8'h00) begin
            errors++;
            $display("FAIL reset_result8: got %h/%h required 00/00", res8[0], res8[1]);
        end
        checks++;
        if (busy64[0] !== 1'b0 || res64[3] !== 64'h0) begin
            errors++;
            $display("FAIL reset_64: busy %b result %h required 0/0", busy64[0], res64[3]);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_overflow;
        int lat;
        run8(0, 1'b0, 8'h7F, 8'h01, lat);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL add_ovf_latency: got %0d required 8", lat);
        end
        checks++;
        if (res8[0] !== 8'h80 || {cout8[0], ovf8[0], zero8[0], neg8[0]} !== 4'b0101) begin
            errors++;
            $display("FAIL add_ovf: got %h c/v/z/n %b required 80 0101", res8[0],
                     {cout8[0], ovf8[0], zero8[0], neg8[0]});
        end
    endtask

    task automatic test_add_carry;
        int lat;
        run8(0, 1'b0, 8'hFF, 8'h01, lat);
        checks++;
        if (lat != 8 || res8[0] !== 8'h00 || {cout8[0], ovf8[0], zero8[0], neg8[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL add_carry: lat %0d got %h c/v/z/n %b required 8 00 1010", lat, res8[0],
                     {cout8[0], ovf8[0], zero8[0], neg8[0]});
        end
    endtask

    task automatic test_sub_borrow;
        int lat;
        run8(0, 1'b1, 8'h05, 8'h07, lat);
        checks++;
        if (lat != 8 || res8[0] !== 8'hFE || {cout8[0], ovf8[0], zero8[0], neg8[0]} !== 4'b0001) begin
            errors++;
            $display("FAIL sub_borrow: lat %0d got %h c/v/z/n %b required 8 FE 0001", lat, res8[0],
                     {cout8[0], ovf8[0], zero8[0], neg8[0]});
        end
    endtask

    task automatic test_digit4;
        int lat;
        run8(1, 1'b1, 8'h80, 8'h01, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL digit4_latency: got %0d required 2", lat);
        end
        checks++;
        if (res8[1] !== 8'h7F || cout8[1] !== 1'b1 || ovf8[1] !== 1'b1) begin
            errors++;
            $display("FAIL digit4_sub: got %h c %b v %b required 7F 1 1", res8[1], cout8[1], ovf8[1]);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        int early;
        wait_idle8();
        sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) begin
                a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8[0] === 1'b1) pulses++;
        end
        checks++;
        if (done8[0] !== 1'b1 || pulses != 1 || res8[0] !== 8'h30) begin
            errors++;
            $display("FAIL busy_ignore: done %b pulses %0d result %h required 1 1 30",
                     done8[0], pulses, res8[0]);
        end
        // Issue the next request inside the done cycle.
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        early = 0;
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (res8[0] !== 8'h30 || done8[0] !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL b2b_hold: %0d cycles with result changed or early done, required 0", early);
        end
        tick();
        checks++;
        if (done8[0] !== 1'b1 || res8[0] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_result: done %b result %h required 1 FF", done8[0], res8[0]);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        int lat;
        wait_idle8();
        sub8 = 1'b0; a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy8[0], done8[0], cout8[0], ovf8[0], zero8[0], neg8[0]} !== 6'b0 || res8[0] !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: ctrl %b result %h required 000000 00",
                     {busy8[0], done8[0], cout8[0], ovf8[0], zero8[0], neg8[0]}, res8[0]);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8[0] !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: got %0d done cycles required 0", pulses);
        end
        run8(0, 1'b0, 8'h33, 8'h44, lat);
        checks++;
        if (lat != 8 || res8[0] !== 8'h77) begin
            errors++;
            $display("FAIL after_reset: lat %0d result %h required 8 77", lat, res8[0]);
        end
    endtask

    task automatic test_random64;
        logic [63:0] bb;
        logic [64:0] full;
        logic        ov;
        int          lat [4];
        for (int n = 0; n < 250; n++) begin
            a64   = {$urandom, $urandom};
            b64   = {$urandom, $urandom};
            sub64 = 1'($urandom_range(0, 1));
            if (n == 0) begin a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1; sub64 = 1'b0; end
            if (n == 1) begin a64 = 64'h0; b64 = 64'h1; sub64 = 1'b1; end
            bb   = sub64 ? ~b64 : b64;
            full = {1'b0, a64} + {1'b0, bb} + 65'(sub64);
            ov   = (a64[63] == bb[63]) && (full[63] != a64[63]);
            start64 = 1'b1;
            tick();
            start64 = 1'b0;
            for (int g = 0; g < 4; g++) lat[g] = 0;
            for (int t = 1; t <= 80 && lat[0] == 0; t++) begin
                tick();
                for (int g = 0; g < 4; g++) begin
                    if (done64[g] === 1'b1 && lat[g] == 0) lat[g] = t;
                end
            end
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (lat[g] != 64 / C_DIGS[g] || res64[g] !== full[63:0] || cout64[g] !== full[64]
                    || ovf64[g] !== ov) begin
                    errors++;
                    $display("FAIL rand64 d%0d op%0d: lat %0d res %h c %b v %b required %0d %h %b %b",
                             C_DIGS[g], n, lat[g], res64[g], cout64[g], ovf64[g],
                             64 / C_DIGS[g], full[63:0], full[64], ov);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start64 = 1'b0; sub64 = 1'b0; a64 = 64'h0; b64 = 64'h0;
        test_reset();
        test_add_overflow();
        test_add_carry();
        test_sub_borrow();
        test_digit4();
        test_back_to_back();
        test_reset_mid();
        test_random64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
